// File: rtl/reservation_station_if.sv
// Issue-side bus of the reservation station: dispatch in, result broadcasts in, ALU issue out.
// The master drives dispatch/broadcasts; the slave (the RS) drives back-pressure and issue.
interface reservation_station_if #(
    parameter int ROB_W = 5
);
    logic             disp_valid;
    logic [6:0]       disp_op;
    logic [31:0]      disp_imm;
    logic [31:0]      disp_pc;
    logic [ROB_W-1:0] disp_Qi;
    logic [ROB_W-1:0] disp_Qj;
    logic [31:0]      disp_Vi;
    logic [31:0]      disp_Vj;
    logic [ROB_W-1:0] disp_rd;
    logic             rs_full;

    logic             alu_valid;
    logic [ROB_W-1:0] alu_rob_id;
    logic [31:0]      alu_res;
    logic             lsb_valid;
    logic [ROB_W-1:0] lsb_rob_id;
    logic [31:0]      lsb_res;

    logic             ex_en;
    logic [6:0]       ex_op;
    logic [31:0]      ex_Vi;
    logic [31:0]      ex_Vj;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_pc;
    logic [ROB_W-1:0] ex_rob_id;

    modport master (
        output disp_valid, disp_op, disp_imm, disp_pc, disp_Qi, disp_Qj, disp_Vi, disp_Vj, disp_rd,
        output alu_valid, alu_rob_id, alu_res, lsb_valid, lsb_rob_id, lsb_res,
        input  rs_full, ex_en, ex_op, ex_Vi, ex_Vj, ex_imm, ex_pc, ex_rob_id
    );

    modport slave (
        input  disp_valid, disp_op, disp_imm, disp_pc, disp_Qi, disp_Qj, disp_Vi, disp_Vj, disp_rd,
        input  alu_valid, alu_rob_id, alu_res, lsb_valid, lsb_rob_id, lsb_res,
        output rs_full, ex_en, ex_op, ex_Vi, ex_Vj, ex_imm, ex_pc, ex_rob_id
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: buffers renamed ALU ops, wakes operands from ALU/LSB broadcasts,
// issues the lowest-index ready entry each cycle. One rs_entry instance per slot.
module rs_entry #(
    parameter int ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alloc,
    input  logic             issue,
    input  logic [6:0]       disp_op,
    input  logic [31:0]      disp_imm,
    input  logic [31:0]      disp_pc,
    input  logic [ROB_W-1:0] disp_Qi,
    input  logic [ROB_W-1:0] disp_Qj,
    input  logic [31:0]      disp_Vi,
    input  logic [31:0]      disp_Vj,
    input  logic [ROB_W-1:0] disp_rd,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic [31:0]      alu_res,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic [31:0]      lsb_res,
    output logic             busy,
    output logic             ready,
    output logic [6:0]       op,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [31:0]      Vi,
    output logic [31:0]      Vj,
    output logic [ROB_W-1:0] rd
);
    logic [ROB_W-1:0] Qi, Qj;
    logic [ROB_W-1:0] qi_src, qj_src, qi_nxt, qj_nxt;
    logic [31:0]      vi_src, vj_src, vi_nxt, vj_nxt;

    // Tag 0 means "value present" and must never be matched by a broadcast.
    function automatic logic [ROB_W+31:0] wake(
        input logic [ROB_W-1:0] q, input logic [31:0] v,
        input logic av, input logic [ROB_W-1:0] aid, input logic [31:0] ares,
        input logic lv, input logic [ROB_W-1:0] lid, input logic [31:0] lres
    );
        if (q != '0 && av && aid == q)      return {{ROB_W{1'b0}}, ares};
        else if (q != '0 && lv && lid == q) return {{ROB_W{1'b0}}, lres};
        else                                return {q, v};
    endfunction

    // An arriving entry snoops on its dispatch tags so a same-cycle broadcast is not lost.
    always_comb begin
        qi_src = alloc ? disp_Qi : Qi;
        qj_src = alloc ? disp_Qj : Qj;
        vi_src = alloc ? disp_Vi : Vi;
        vj_src = alloc ? disp_Vj : Vj;
        {qi_nxt, vi_nxt} = wake(qi_src, vi_src, alu_valid, alu_rob_id, alu_res,
                                lsb_valid, lsb_rob_id, lsb_res);
        {qj_nxt, vj_nxt} = wake(qj_src, vj_src, alu_valid, alu_rob_id, alu_res,
                                lsb_valid, lsb_rob_id, lsb_res);
    end

    assign ready = busy && (Qi == '0) && (Qj == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            op   <= '0;
            imm  <= '0;
            pc   <= '0;
            rd   <= '0;
            Qi   <= '0;
            Qj   <= '0;
            Vi   <= '0;
            Vj   <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (rdy) begin
            if (alloc) begin
                busy <= 1'b1;
                op   <= disp_op;
                imm  <= disp_imm;
                pc   <= disp_pc;
                rd   <= disp_rd;
            end else if (issue) begin
                busy <= 1'b0;
            end
            if (alloc || busy) begin
                Qi <= qi_nxt;
                Qj <= qj_nxt;
                Vi <= vi_nxt;
                Vj <= vj_nxt;
            end
        end
    end
endmodule

module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    input  logic wrong_commit,
    reservation_station_if.slave bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]             busy, ready, alloc_vec, issue_vec;
    logic [RS_SIZE-1:0][6:0]        e_op;
    logic [RS_SIZE-1:0][31:0]       e_imm, e_pc, e_Vi, e_Vj;
    logic [RS_SIZE-1:0][ROB_W-1:0]  e_rd;
    logic [IDX_W-1:0]               alloc_idx, issue_idx;
    logic                           alloc_ok, issue_ok, alloc_en, issue_en;
    logic [CNT_W-1:0]               busy_cnt;

    // Descending scan so the lowest free / lowest ready index wins.
    always_comb begin
        alloc_idx = '0;
        alloc_ok  = 1'b0;
        issue_idx = '0;
        issue_ok  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_idx = IDX_W'(i);
                alloc_ok  = 1'b1;
            end
            if (ready[i]) begin
                issue_idx = IDX_W'(i);
                issue_ok  = 1'b1;
            end
        end
    end

    assign alloc_en  = bus.disp_valid && alloc_ok;
    assign issue_en  = issue_ok;
    assign alloc_vec = alloc_en ? (RS_SIZE'(1) << alloc_idx) : '0;
    assign issue_vec = issue_en ? (RS_SIZE'(1) << issue_idx) : '0;

    // Counting the in-flight dispatch leaves room for the dispatcher's register stage.
    assign bus.rs_full = ({1'b0, busy_cnt} + (CNT_W+1)'(bus.disp_valid)) >= (CNT_W+1)'(RS_SIZE);

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
        rs_entry #(.ROB_W(ROB_W)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .rdy        (rdy),
            .flush      (wrong_commit),
            .alloc      (alloc_vec[g]),
            .issue      (issue_vec[g]),
            .disp_op    (bus.disp_op),
            .disp_imm   (bus.disp_imm),
            .disp_pc    (bus.disp_pc),
            .disp_Qi    (bus.disp_Qi),
            .disp_Qj    (bus.disp_Qj),
            .disp_Vi    (bus.disp_Vi),
            .disp_Vj    (bus.disp_Vj),
            .disp_rd    (bus.disp_rd),
            .alu_valid  (bus.alu_valid),
            .alu_rob_id (bus.alu_rob_id),
            .alu_res    (bus.alu_res),
            .lsb_valid  (bus.lsb_valid),
            .lsb_rob_id (bus.lsb_rob_id),
            .lsb_res    (bus.lsb_res),
            .busy       (busy[g]),
            .ready      (ready[g]),
            .op         (e_op[g]),
            .imm        (e_imm[g]),
            .pc         (e_pc[g]),
            .Vi         (e_Vi[g]),
            .Vj         (e_Vj[g]),
            .rd         (e_rd[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt      <= '0;
            bus.ex_en     <= 1'b0;
            bus.ex_op     <= '0;
            bus.ex_Vi     <= '0;
            bus.ex_Vj     <= '0;
            bus.ex_imm    <= '0;
            bus.ex_pc     <= '0;
            bus.ex_rob_id <= '0;
        end else if (wrong_commit) begin
            busy_cnt  <= '0;
            bus.ex_en <= 1'b0;
        end else if (rdy) begin
            busy_cnt  <= busy_cnt + CNT_W'(alloc_en) - CNT_W'(issue_en);
            bus.ex_en <= issue_en;
            if (issue_en) begin
                bus.ex_op     <= e_op[issue_idx];
                bus.ex_Vi     <= e_Vi[issue_idx];
                bus.ex_Vj     <= e_Vj[issue_idx];
                bus.ex_imm    <= e_imm[issue_idx];
                bus.ex_pc     <= e_pc[issue_idx];
                bus.ex_rob_id <= e_rd[issue_idx];
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: per-scenario tasks plus an issue scoreboard.
module tb_reservation_station;
    logic clk = 1'b0;
    logic rst_n, rdy, wrong_commit;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [6:0]  op;
        logic [31:0] vi, vj, imm, pc;
        logic [4:0]  rob;
    } exp_t;
    exp_t sb[$];

    reservation_station_if #(.ROB_W(5)) bus ();

    reservation_station #(.RS_SIZE(16), .ROB_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .wrong_commit (wrong_commit),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.ex_en === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got ex_en=1 rob=%0d, expected no issue", bus.ex_rob_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.ex_op !== e.op || bus.ex_Vi !== e.vi || bus.ex_Vj !== e.vj ||
                    bus.ex_imm !== e.imm || bus.ex_pc !== e.pc || bus.ex_rob_id !== e.rob) begin
                    n_fail++;
                    $display("FAIL issue_fields: got op=%h vi=%h vj=%h imm=%h pc=%h rob=%0d, expected op=%h vi=%h vj=%h imm=%h pc=%h rob=%0d",
                             bus.ex_op, bus.ex_Vi, bus.ex_Vj, bus.ex_imm, bus.ex_pc, bus.ex_rob_id,
                             e.op, e.vi, e.vj, e.imm, e.pc, e.rob);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.alu_valid  = 1'b0;
        bus.lsb_valid  = 1'b0;
    endtask

    task automatic drive_disp(input logic [6:0] op, input logic [4:0] qi, input logic [31:0] vi,
                              input logic [4:0] qj, input logic [31:0] vj, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [31:0] pc);
        bus.disp_valid = 1'b1;
        bus.disp_op    = op;
        bus.disp_Qi    = qi;
        bus.disp_Vi    = vi;
        bus.disp_Qj    = qj;
        bus.disp_Vj    = vj;
        bus.disp_rd    = rd;
        bus.disp_imm   = imm;
        bus.disp_pc    = pc;
    endtask

    task automatic push_exp(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rob);
        exp_t e;
        e.op = op; e.vi = vi; e.vj = vj; e.imm = imm; e.pc = pc; e.rob = rob;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; wrong_commit = 1'b1;
        drive_disp(7'h33, 5'd0, 32'd1, 5'd0, 32'd2, 5'd1, 32'd0, 32'd0);
        bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_res = '0;
        bus.lsb_valid = 1'b0; bus.lsb_rob_id = '0; bus.lsb_res = '0;
        cycle(); cycle();
        idle(); wrong_commit = 1'b0;
        #1;
        n_tests++;
        if (bus.ex_en !== 1'b0 || bus.rs_full !== 1'b0 || dut.busy_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ex_en=%b rs_full=%b busy_cnt=%0d, expected 0 0 0",
                     bus.ex_en, bus.rs_full, dut.busy_cnt);
        end
        n_tests++;
        if ({bus.ex_op, bus.ex_Vi, bus.ex_Vj, bus.ex_imm, bus.ex_pc, bus.ex_rob_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_ex: got op=%h vi=%h vj=%h imm=%h pc=%h rob=%0d, expected all 0",
                     bus.ex_op, bus.ex_Vi, bus.ex_Vj, bus.ex_imm, bus.ex_pc, bus.ex_rob_id);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic check_en(input string name, input logic exp);
        n_tests++;
        if (bus.ex_en !== exp) begin
            n_fail++;
            $display("FAIL %s: got ex_en=%b, expected %b", name, bus.ex_en, exp);
        end
    endtask

    task automatic test_ready_dispatch();
        drive_disp(7'h33, 5'd0, 32'd5, 5'd0, 32'd7, 5'd3, 32'h100, 32'h1000);
        push_exp(7'h33, 32'd5, 32'd7, 32'h100, 32'h1000, 5'd3);
        cycle(); idle();
        check_en("ready_t0", 1'b0);
        cycle();
        check_en("ready_t1", 1'b1);
        cycle();
        check_en("ready_t2", 1'b0);
    endtask

    task automatic test_wakeup();
        drive_disp(7'h13, 5'd4, 32'hDEAD, 5'd0, 32'd1, 5'd5, 32'h8, 32'h1004);
        cycle(); idle();
        check_en("wake_pending0", 1'b0);
        cycle();
        check_en("wake_pending1", 1'b0);
        bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd4; bus.alu_res = 32'h10;
        push_exp(7'h13, 32'h10, 32'd1, 32'h8, 32'h1004, 5'd5);
        cycle(); idle();
        check_en("wake_bcast", 1'b0);
        cycle();
        check_en("wake_issue", 1'b1);
        cycle();
        check_en("wake_after", 1'b0);
    endtask

    task automatic test_same_cycle_snoop();
        drive_disp(7'h3B, 5'd0, 32'd2, 5'd6, 32'h0, 5'd7, 32'hC, 32'h1008);
        bus.lsb_valid = 1'b1; bus.lsb_rob_id = 5'd6; bus.lsb_res = 32'hAB;
        push_exp(7'h3B, 32'd2, 32'hAB, 32'hC, 32'h1008, 5'd7);
        cycle(); idle();
        check_en("snoop_t0", 1'b0);
        cycle();
        check_en("snoop_issue", 1'b1);
        cycle();
        check_en("snoop_after", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            drive_disp(7'h20 + 7'(k), 5'd0, 32'd100 + k, 5'd0, 32'd200 + k, 5'd10 + 5'(k),
                       32'(k), 32'h3000 + 32'(k));
            push_exp(7'h20 + 7'(k), 32'd100 + k, 32'd200 + k, 32'(k), 32'h3000 + 32'(k), 5'd10 + 5'(k));
            cycle();
            check_en("b2b_pipe", k > 0);
        end
        idle();
        cycle();
        check_en("b2b_tail1", 1'b1);
        cycle();
        check_en("b2b_tail2", 1'b0);
    endtask

    task automatic test_full();
        for (int k = 0; k < 16; k++) begin
            drive_disp(7'h40 + 7'(k), 5'd9, 32'h0, 5'd0, 32'(k), 5'(k + 1), 32'(k * 4), 32'h2000 + 32'(k * 4));
            #1;
            n_tests++;
            if (bus.rs_full !== (k == 15)) begin
                n_fail++;
                $display("FAIL full_fill: got rs_full=%b at dispatch %0d, expected %b", bus.rs_full, k, (k == 15));
            end
            cycle();
        end
        idle();
        #1;
        n_tests++;
        if (bus.rs_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: got rs_full=%b, expected 1", bus.rs_full);
        end
        bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd9; bus.alu_res = 32'h99;
        for (int k = 0; k < 16; k++)
            push_exp(7'h40 + 7'(k), 32'h99, 32'(k), 32'(k * 4), 32'h2000 + 32'(k * 4), 5'(k + 1));
        cycle(); idle();
        check_en("full_bcast", 1'b0);
        for (int k = 0; k < 16; k++) begin
            cycle();
            check_en("full_drain", 1'b1);
        end
        cycle();
        check_en("full_done", 1'b0);
        n_tests++;
        if (sb.size() != 0 || bus.rs_full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty: got %0d pending, rs_full=%b, expected 0 pending, rs_full=0", sb.size(), bus.rs_full);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            drive_disp(7'h50, 5'd12, 32'h0, 5'd0, 32'(k), 5'd20 + 5'(k), 32'h0, 32'h4000);
            cycle();
        end
        drive_disp(7'h51, 5'd0, 32'd1, 5'd0, 32'd2, 5'd25, 32'h0, 32'h4010);
        wrong_commit = 1'b1;
        cycle();
        idle(); wrong_commit = 1'b0;
        #1;
        n_tests++;
        if (dut.busy_cnt !== 5'd0 || bus.ex_en !== 1'b0 || bus.rs_full !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: got busy_cnt=%0d ex_en=%b rs_full=%b, expected 0 0 0",
                     dut.busy_cnt, bus.ex_en, bus.rs_full);
        end
        bus.alu_valid = 1'b1; bus.alu_rob_id = 5'd12; bus.alu_res = 32'h55;
        cycle(); idle();
        for (int k = 0; k < 4; k++) begin
            check_en("flush_quiet", 1'b0);
            cycle();
        end
    endtask

    task automatic test_rdy_freeze();
        rdy = 1'b0;
        drive_disp(7'h60, 5'd0, 32'd3, 5'd0, 32'd4, 5'd30, 32'h0, 32'h5000);
        cycle(); idle();
        cycle();
        n_tests++;
        if (dut.busy_cnt !== 5'd0 || bus.ex_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_freeze: got busy_cnt=%0d ex_en=%b, expected 0 0", dut.busy_cnt, bus.ex_en);
        end
        rdy = 1'b1;
        cycle();
        check_en("rdy_resume", 1'b0);
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_same_cycle_snoop();
        test_back_to_back();
        test_full();
        test_flush();
        test_rdy_freeze();
        cycle();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding issues, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
